// File: rtl/se_violation_mon_if.sv
// Parsed receive word stream feeding the frame-protocol violation monitor.
// The link engine drives it as master; the monitor observes it as slave.
interface se_violation_mon_if;
  logic sop;
  logic eop;
  logic valid;
  logic active;

  modport master (output sop, output eop, output valid, output active);
  modport slave  (input  sop, input  eop, input  valid, input  active);
endinterface

// File: rtl/se_violation_mon.sv
// Per-link frame-protocol violation monitor on the parsed sop/eop/valid stream.
// Optional saturating violation counter is compiled in with `define SE_VIOL_CNT_EN.
module se_violation_mon #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int MIN_LEN     = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  se_violation_mon_if.slave    rx,
  input  logic                 clr_cnt,
  output logic                 inframe,
  output logic                 violation,
  output logic [4:0]           viol_code,
  output logic                 eop_bb,
  output logic [CNT_W-1:0]     viol_cnt
);

  localparam int LEN_W  = (MIN_LEN < 1) ? 1 : $clog2(MIN_LEN + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {S_IDLE = 1'b0, S_INFRAME = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;

  logic                sop_v, eop_v, in_f, timeout_hit;
  logic [4:0]          code_d;
  logic                eop_bb_d;

  logic [4:0]          viol_code_p1;
  logic                vld_p1;
  logic                eop_bb_p1;

  // Length counter stops at MIN_LEN: longer frames are never runts.
  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
    if (v >= LEN_W'(MIN_LEN)) return v;
    else                      return v + LEN_W'(1);
  endfunction

  assign sop_v       = rx.sop & rx.valid;
  assign eop_v       = rx.eop & rx.valid;
  assign in_f        = (state_q == S_INFRAME);
  assign timeout_hit = in_f & ~rx.valid & (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idle_d  = idle_q;
    if (sop_v && eop_v) begin
      state_d = S_IDLE;
    end else if (sop_v) begin
      // A sop always (re)starts a frame, even with active low.
      state_d = S_INFRAME;
      len_d   = LEN_W'(1);
      idle_d  = '0;
    end else if (in_f) begin
      if (eop_v || !rx.active || timeout_hit) begin
        state_d = S_IDLE;
      end else if (rx.valid) begin
        len_d  = len_sat_inc(len_q);
        idle_d = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
    if (state_d == S_IDLE) begin
      len_d  = '0;
      idle_d = '0;
    end
  end

  always_comb begin
    code_d    = '0;
    eop_bb_d  = 1'b0;
    code_d[0] = timeout_hit;
    code_d[1] = in_f & eop_v & ~sop_v & (len_q < LEN_W'(MIN_LEN - 1));
    code_d[2] = sop_v & eop_v;
    code_d[3] = in_f & ~rx.active;
    code_d[4] = in_f & sop_v;
    eop_bb_d  = ~in_f & eop_v & ~sop_v;
  end

  // Stage p1: registered cause mask and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_code_p1 <= '0;
      vld_p1       <= 1'b0;
      eop_bb_p1    <= 1'b0;
    end else begin
      viol_code_p1 <= code_d;
      vld_p1       <= |code_d;
      eop_bb_p1    <= eop_bb_d;
    end
  end

  assign inframe   = in_f;
  assign violation = vld_p1;
  assign viol_code = viol_code_p1;
  assign eop_bb    = eop_bb_p1;

`ifdef SE_VIOL_CNT_EN
  logic [CNT_W-1:0] cnt_p2;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + CNT_W'(1);
  endfunction

  // Stage p2: count registered violation pulses; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_p2 <= '0;
    else if (clr_cnt) cnt_p2 <= '0;
    else if (vld_p1)  cnt_p2 <= cnt_sat_inc(cnt_p2);
  end

  assign viol_cnt = cnt_p2;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign viol_cnt       = '0;
`endif

endmodule
